apb_master_bridge: RTL and testbench

//  Converts a valid/ready command stream (addr, write, wdata) into single APB3 transfers and returns a

---
 rtl/apb_pkg.sv | 13 +
 rtl/apb_timeout_cnt.sv | 31 +++
 rtl/apb_master_bridge.sv | 102 ++++++++++
 tb/tb_apb_master_bridge.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions used by the bridge, the slave memory block and the bench.
package apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS,
    APB_RESP
  } apb_state_e;

  localparam int APB_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Watchdog counter for the APB ACCESS phase: counts wait cycles and flags the last allowed one.
module apb_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt;

  // Saturates at TIMEOUT so a stuck enable can never wrap back to a live value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != SAT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command stream to single APB3 transfers, with a watchdog on pready.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = APB_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_e state_reg;
  apb_state_e state_next;
  logic       expired;
  logic       cnt_clr;
  logic       cnt_en;

  assign cmd_ready = (state_reg == APB_IDLE);
  assign cnt_clr   = (state_reg == APB_SETUP);
  assign cnt_en    = (state_reg == APB_ACCESS) && !pready;

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= APB_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // pready outside ACCESS (the registered slave's trailing cycle) is never looked at.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      APB_IDLE:   if (cmd_valid) state_next = APB_SETUP;
      APB_SETUP:  state_next = APB_ACCESS;
      APB_ACCESS: if (pready || expired) state_next = APB_RESP;
      APB_RESP:   if (rsp_ready) state_next = APB_IDLE;
      default:    state_next = APB_IDLE;
    endcase
  end

  // APB and response outputs are registered from the next state so they change on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psel      <= 1'b0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      psel      <= (state_next == APB_SETUP) || (state_next == APB_ACCESS);
      penable   <= (state_next == APB_ACCESS);
      rsp_valid <= (state_next == APB_RESP);
      if ((state_reg == APB_IDLE) && cmd_valid) begin
        paddr  <= cmd_addr;
        pwrite <= cmd_write;
        pwdata <= cmd_wdata;
      end
      if (state_reg == APB_ACCESS) begin
        if (pready) begin
          rsp_err   <= pslverr;
          rsp_rdata <= pwrite ? '0 : prdata;
        end else if (expired) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench: bridge paired with a registered-pready APB memory model that can also error or stall.
module tb_apb_master_bridge;
  import apb_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          mode = 0;  // 0 normal, 1 pslverr, 2 never ready
  int          setup_cnt = 0;
  int          idle_psel_viol = 0;
  logic [31:0] mem [0:255];

  apb_master_bridge #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (APB_TIMEOUT_DEFAULT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_write (cmd_write),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  end

  // Slave registers pready, so it stays high for one cycle after psel drops.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= 32'h0;
    end else begin
      pready  <= psel && penable && (mode != 2);
      pslverr <= psel && penable && (mode == 1);
      prdata  <= (psel && penable) ? mem[paddr[7:0]] : 32'h0;
      if (psel && penable && pwrite && (mode == 0)) mem[paddr[7:0]] <= pwdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    rsp_t e;
    if (reset_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got rdata=0x%08h err=%0d expected no response", rsp_rdata, rsp_err);
      end else begin
        e = exp_q.pop_front();
        $display("rsp rdata=0x%08h err=%0d (exp 0x%08h/%0d)", rsp_rdata, rsp_err, e.rdata, e.err);
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (psel && !penable) setup_cnt++;
      if (psel && cmd_ready) idle_psel_viol++;
    end
  end

  task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [31:0] er, input logic ee, input bit expect_rsp);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_write = w;
    cmd_wdata = d;
    if (expect_rsp) exp_q.push_back('{rdata: er, err: ee});
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept: got cmd_ready=0 for %0d cycles expected 1", n);
    end
    $display("cmd addr=0x%08h write=%0d wdata=0x%08h", a, w, d);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int acc;
    int base;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = 32'h0;
    cmd_write = 1'b0;
    cmd_wdata = 32'h0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_pwrite", 32'(pwrite), 32'd0);
    check("rst_paddr", paddr, 32'h0);
    check("rst_pwdata", pwdata, 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // T1: write, then read with cycle-by-cycle latency checks
    send(32'h10, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    drain();
    send(32'h10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    check("t1_c1_psel", 32'(psel), 32'd1);
    check("t1_c1_penable", 32'(penable), 32'd0);
    @(negedge clk);
    check("t1_c2_penable", 32'(penable), 32'd1);
    check("t1_c2_paddr", paddr, 32'h10);
    check("t1_c2_pwrite", 32'(pwrite), 32'd0);
    @(negedge clk);
    check("t1_c3_penable", 32'(penable), 32'd1);
    check("t1_c3_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("t1_c4_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_c4_psel", 32'(psel), 32'd0);
    @(negedge clk);
    check("t1_c5_cmd_ready", 32'(cmd_ready), 32'd1);
    check("t1_c5_rsp_valid", 32'(rsp_valid), 32'd0);
    drain();

    // T2: response backpressure
    rsp_ready = 1'b0;
    send(32'h10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    acc = 0;
    while (!rsp_valid && acc < 50) begin
      @(negedge clk);
      acc++;
    end
    for (int i = 0; i < 5; i++) begin
      check("t2_rsp_valid", 32'(rsp_valid), 32'd1);
      check("t2_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      check("t2_cmd_ready", 32'(cmd_ready), 32'd0);
      check("t2_psel", 32'(psel), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    drain();

    // T3: back-to-back writes with cmd_valid held high, then read-back
    base = setup_cnt;
    for (int i = 0; i < 4; i++)
      send(32'h20 + 32'(i), 1'b1, 32'hA5A50000 + 32'(i), 32'h0, 1'b0, 1'b1);
    drain();
    check("t3_setup_phases", 32'(setup_cnt - base), 32'd4);
    check("t3_idle_psel", 32'(idle_psel_viol), 32'd0);
    for (int i = 0; i < 4; i++)
      send(32'h20 + 32'(i), 1'b0, 32'h0, 32'hA5A50000 + 32'(i), 1'b0, 1'b1);
    drain();

    // T4: slave error, then a clean transfer
    mode = 1;
    send(32'h30, 1'b1, 32'h12345678, 32'h0, 1'b1, 1'b1);
    drain();
    mode = 0;
    send(32'h30, 1'b1, 32'h12345678, 32'h0, 1'b0, 1'b1);
    drain();
    send(32'h30, 1'b0, 32'h0, 32'h12345678, 1'b0, 1'b1);
    drain();

    // T5: slave never ready, watchdog ends the transfer
    mode = 2;
    send(32'h10, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    acc = 0;
    for (int n = 0; n < 100 && !rsp_valid; n++) begin
      @(negedge clk);
      if (psel && penable) acc++;
    end
    check("t5_access_cycles", 32'(acc), 32'd16);
    drain();

    // T6: reset during ACCESS
    send(32'h10, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("t6_pre_penable", 32'(penable), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6_psel", 32'(psel), 32'd0);
    check("t6_penable", 32'(penable), 32'd0);
    check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    mode = 0;
    @(negedge clk);
    check("t6_cmd_ready", 32'(cmd_ready), 32'd1);
    check("t6_psel_after", 32'(psel), 32'd0);
    send(32'h21, 1'b0, 32'h0, 32'hA5A50001, 1'b0, 1'b1);
    drain();
    repeat (3) @(negedge clk);
    check("end_queue", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
